dirv_lsu: RTL
=============

Name: dirv_lsu

Overview:
- Load/store unit sitting directly upstream of the data-memory port (dmem_*) of the memory model/controller.
- Accepts one load or store request from the execute stage and drives the dmem address/read/write channels.
- Formats byte/half/word write strobes and data; sign- or zero-extends load data.
- Single outstanding transaction; misaligned requests are rejected with no bus activity.

Parameters:
- p_ADDR_BITS, 32, byte-address width.
- p_DATA_BITS, 32, data width; only 32 is supported.
- p_STRB_BITS, p_DATA_BITS/8, write-strobe width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-low reset.
- req_valid  in  1  request valid.
- req_ready  out  1  LSU idle, can accept a request.
- req_cmd  in  1  0 = load, 1 = store.
- req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = illegal.
- req_unsigned  in  1  load zero-extends when 1.
- req_addr  in  p_ADDR_BITS  byte address.
- req_wdata  in  p_DATA_BITS  store data, right-aligned.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  p_DATA_BITS  extended load data; 0 for stores.
- rsp_err  out  1  bus error or illegal size.
- rsp_misaligned  out  1  misaligned access.
- mem_addr  out  p_ADDR_BITS  word-aligned address {addr[31:2],2'b00}.
- mem_cmd  out  1  0 = read, 1 = write.
- mem_valid  out  1  address phase valid.
- mem_ready  in  1  address accepted.
- mem_r_ready  out  1  ready for read data.
- mem_r_valid  in  1  read data valid.
- mem_r_data  in  p_DATA_BITS  read word.
- mem_r_resp  in  1  read error, valid with mem_r_valid.
- mem_w_valid  out  1  write data valid.
- mem_w_ready  in  1  write data accepted.
- mem_w_strb  out  p_STRB_BITS  byte enables.
- mem_w_data  out  p_DATA_BITS  lane-replicated write data.
- mem_w_resp  in  1  write error, valid with the mem_w handshake.

Behaviour:
- Reset (rst==0 at a clk edge):
  - State goes to IDLE.
  - All outputs are 0, except req_ready=1 after reset.
  - Reset mid-transaction abandons it silently; no rsp_valid.
- FSM states: IDLE, ADDR, RDATA, WDATA, RESP.
  - req_ready = (state==IDLE).
- IDLE, on req_valid && req_ready:
  - Register all req_* fields.
  - Misaligned (half with addr[0]=1, or word with addr[1:0]!=0) or req_size==3: go to RESP with misaligned/err flags set; no mem_valid, ever.
  - Otherwise go to ADDR.
- ADDR:
  - mem_valid=1; mem_addr/mem_cmd are stable from registers.
  - Hold until mem_ready.
  - On handshake, loads go to RDATA and stores go to WDATA.
- RDATA:
  - mem_r_ready=1.
  - On mem_r_valid, capture extended data and mem_r_resp, then go to RESP.
- WDATA:
  - mem_w_valid=1; mem_w_strb/mem_w_data are stable.
  - On mem_w_ready, capture mem_w_resp, then go to RESP.
- RESP:
  - rsp_valid=1 for exactly one cycle; rsp_* are valid only in this cycle.
  - Go to IDLE.
  - There is no response backpressure.
- Minimum latency, accept to rsp_valid, with mem_ready/r_valid/w_ready all immediately high: 3 cycles (accept t0, ADDR t1, RDATA/WDATA t2, RESP t3). Misaligned: 1 cycle.
- Store strobe, with o = addr[1:0]:
  - byte: 4'b0001<<o.
  - half: 4'b0011<<o.
  - word: 4'b1111.
- Store data: byte {4{wdata[7:0]}}; half {2{wdata[15:0]}}; word as-is.
- Load:
  - sh = mem_r_data >> (8*o).
  - byte: sign- or zero-extend sh[7:0]; half: sign- or zero-extend sh[15:0]; word: sh.
- rsp_err = bus resp | illegal size.
- rsp_misaligned excludes the illegal-size case.
- req_* inputs are ignored outside IDLE.

Decomposition:
- Package dirv_lsu_pkg:
  - Size encodings SZ_BYTE/SZ_HALF/SZ_WORD.
  - CMD_LOAD/CMD_STORE.
  - FSM state enum.
- Sub-module dirv_lsu_align, purely combinational: misalign check, strobe and write-data replication, load shift/extend.
- dirv_lsu holds only the FSM and registers.

Test Plan:
- Load word, addr 0x100, mem returns 0xDEADBEEF with zero-wait handshakes -> mem_addr=0x100, cmd=0; rsp_valid at t3, rsp_rdata=0xDEADBEEF, err=0.
- Load byte signed at 0x103, mem_r_data=0x80FF_0000 -> rsp_rdata=0xFFFFFF80; same with unsigned -> 0x00000080.
- Store half 0x1234 at 0x202 -> mem_addr=0x200, strb=4'b1100, w_data=0x12341234; rsp_valid, rsp_rdata=0.
- Word load at 0x101 -> no mem_valid; rsp_valid next cycle with misaligned=1; req_ready returns the cycle after.
- mem_ready held low 5 cycles and mem_r_valid delayed 3 cycles with r_resp=1 -> mem_valid/mem_addr stable throughout; single rsp_valid with err=1.
- rst low during WDATA -> next cycle mem_w_valid=0, req_ready=1, no rsp_valid.

Source files
------------

// File: rtl/dirv_lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes, command codes,
// FSM states and the natural-alignment rule.
package dirv_lsu_pkg;

  localparam logic [1:0] SZ_BYTE    = 2'd0;
  localparam logic [1:0] SZ_HALF    = 2'd1;
  localparam logic [1:0] SZ_WORD    = 2'd2;
  localparam logic [1:0] SZ_ILLEGAL = 2'd3;

  localparam logic CMD_LOAD  = 1'b0;
  localparam logic CMD_STORE = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ADDR  = 3'd1,
    ST_RDATA = 3'd2,
    ST_WDATA = 3'd3,
    ST_RESP  = 3'd4
  } lsu_state_e;

  // An access must be naturally aligned to its own size. The illegal size is
  // reported separately, so it never counts as misaligned here.
  function automatic logic size_misaligned(input logic [1:0] size, input logic [1:0] off);
    logic mis;
    case (size)
      SZ_HALF: mis = off[0];
      SZ_WORD: mis = (off != 2'b00);
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/dirv_lsu_align.sv
// Combinational byte-lane logic: request legality check on the incoming
// request, plus store strobe/data replication and load shift/extension on the
// registered request.
module dirv_lsu_align
  import dirv_lsu_pkg::*;
#(
  parameter int p_DATA_BITS = 32,
  parameter int p_STRB_BITS = p_DATA_BITS / 8
) (
  input  logic [1:0]             chk_size,
  input  logic [1:0]             chk_off,
  output logic                   chk_illegal,
  output logic                   chk_misaligned,
  input  logic [1:0]             fmt_size,
  input  logic [1:0]             fmt_off,
  input  logic                   fmt_unsigned,
  input  logic [p_DATA_BITS-1:0] fmt_wdata,
  input  logic [p_DATA_BITS-1:0] fmt_rdata,
  output logic [p_STRB_BITS-1:0] fmt_strb,
  output logic [p_DATA_BITS-1:0] fmt_wdata_rep,
  output logic [p_DATA_BITS-1:0] fmt_rdata_ext
);

  logic [p_DATA_BITS-1:0] rdata_sh;

  assign chk_illegal    = (chk_size == SZ_ILLEGAL);
  assign chk_misaligned = size_misaligned(chk_size, chk_off);

  // Byte enables: the access footprint shifted to its byte offset.
  always_comb begin
    case (fmt_size)
      SZ_BYTE: fmt_strb = p_STRB_BITS'(1) << fmt_off;
      SZ_HALF: fmt_strb = p_STRB_BITS'(3) << fmt_off;
      SZ_WORD: fmt_strb = '1;
      default: fmt_strb = '0;
    endcase
  end

  // Replicate the right-aligned store data into every lane so whichever lanes
  // the strobe enables carry the right bytes without an offset-dependent mux.
  genvar gi;
  generate
    for (gi = 0; gi < p_STRB_BITS; gi++) begin : g_lane
      assign fmt_wdata_rep[8*gi +: 8] =
        (fmt_size == SZ_BYTE) ? fmt_wdata[7:0] :
        (fmt_size == SZ_HALF) ? fmt_wdata[8*(gi%2) +: 8] :
                                fmt_wdata[8*gi +: 8];
    end
  endgenerate

  assign rdata_sh = fmt_rdata >> {fmt_off, 3'b000};

  // Right-align the addressed bytes, then sign- or zero-extend.
  always_comb begin
    case (fmt_size)
      SZ_BYTE: fmt_rdata_ext = {{(p_DATA_BITS-8){~fmt_unsigned & rdata_sh[7]}}, rdata_sh[7:0]};
      SZ_HALF: fmt_rdata_ext = {{(p_DATA_BITS-16){~fmt_unsigned & rdata_sh[15]}}, rdata_sh[15:0]};
      default: fmt_rdata_ext = rdata_sh;
    endcase
  end

endmodule

// File: rtl/dirv_lsu.sv
// Load/store unit: one outstanding request, driven onto the data-memory
// address/read/write channels; misaligned or illegal requests complete
// without any bus activity.
module dirv_lsu
  import dirv_lsu_pkg::*;
#(
  parameter int p_ADDR_BITS = 32,
  parameter int p_DATA_BITS = 32,
  parameter int p_STRB_BITS = p_DATA_BITS / 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_cmd,
  input  logic [1:0]             req_size,
  input  logic                   req_unsigned,
  input  logic [p_ADDR_BITS-1:0] req_addr,
  input  logic [p_DATA_BITS-1:0] req_wdata,
  output logic                   rsp_valid,
  output logic [p_DATA_BITS-1:0] rsp_rdata,
  output logic                   rsp_err,
  output logic                   rsp_misaligned,
  output logic [p_ADDR_BITS-1:0] mem_addr,
  output logic                   mem_cmd,
  output logic                   mem_valid,
  input  logic                   mem_ready,
  output logic                   mem_r_ready,
  input  logic                   mem_r_valid,
  input  logic [p_DATA_BITS-1:0] mem_r_data,
  input  logic                   mem_r_resp,
  output logic                   mem_w_valid,
  input  logic                   mem_w_ready,
  output logic [p_STRB_BITS-1:0] mem_w_strb,
  output logic [p_DATA_BITS-1:0] mem_w_data,
  input  logic                   mem_w_resp
);

  lsu_state_e             state_q, state_d;
  logic                   cmd_q, cmd_d;
  logic [1:0]             size_q, size_d;
  logic                   uns_q, uns_d;
  logic [p_ADDR_BITS-1:0] addr_q, addr_d;
  logic [p_DATA_BITS-1:0] wdata_q, wdata_d;
  logic [p_DATA_BITS-1:0] rdata_q, rdata_d;
  logic                   err_q, err_d;
  logic                   mis_q, mis_d;

  logic                   chk_illegal;
  logic                   chk_misaligned;
  logic [p_STRB_BITS-1:0] fmt_strb;
  logic [p_DATA_BITS-1:0] fmt_wdata_rep;
  logic [p_DATA_BITS-1:0] fmt_rdata_ext;

  dirv_lsu_align #(
    .p_DATA_BITS (p_DATA_BITS),
    .p_STRB_BITS (p_STRB_BITS)
  ) u_align (
    .chk_size       (req_size),
    .chk_off        (req_addr[1:0]),
    .chk_illegal    (chk_illegal),
    .chk_misaligned (chk_misaligned),
    .fmt_size       (size_q),
    .fmt_off        (addr_q[1:0]),
    .fmt_unsigned   (uns_q),
    .fmt_wdata      (wdata_q),
    .fmt_rdata      (mem_r_data),
    .fmt_strb       (fmt_strb),
    .fmt_wdata_rep  (fmt_wdata_rep),
    .fmt_rdata_ext  (fmt_rdata_ext)
  );

  // State register; reset abandons any transaction in flight.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Request and response registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cmd_q   <= 1'b0;
      size_q  <= 2'd0;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      cmd_q   <= cmd_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      mis_q   <= mis_d;
    end
  end

  // Next-state logic: rejected requests skip straight to the response.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          state_d = (chk_illegal || chk_misaligned) ? ST_RESP : ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (mem_ready) begin
          state_d = (cmd_q == CMD_STORE) ? ST_WDATA : ST_RDATA;
        end
      end
      ST_RDATA: begin
        if (mem_r_valid) begin
          state_d = ST_RESP;
        end
      end
      ST_WDATA: begin
        if (mem_w_ready) begin
          state_d = ST_RESP;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath capture: request fields on accept, bus results on completion.
  always_comb begin
    cmd_d   = cmd_q;
    size_d  = size_q;
    uns_d   = uns_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    mis_d   = mis_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          cmd_d   = req_cmd;
          size_d  = req_size;
          uns_d   = req_unsigned;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          rdata_d = '0;
          err_d   = chk_illegal;
          mis_d   = chk_misaligned & ~chk_illegal;
        end
      end
      ST_RDATA: begin
        if (mem_r_valid) begin
          rdata_d = fmt_rdata_ext;
          err_d   = mem_r_resp;
        end
      end
      ST_WDATA: begin
        if (mem_w_ready) begin
          err_d = mem_w_resp;
        end
      end
      default: ;
    endcase
  end

  // Outputs decoded from the current state; everything is zero when inactive.
  always_comb begin
    req_ready      = 1'b0;
    rsp_valid      = 1'b0;
    rsp_rdata      = '0;
    rsp_err        = 1'b0;
    rsp_misaligned = 1'b0;
    mem_addr       = '0;
    mem_cmd        = 1'b0;
    mem_valid      = 1'b0;
    mem_r_ready    = 1'b0;
    mem_w_valid    = 1'b0;
    mem_w_strb     = '0;
    mem_w_data     = '0;
    case (state_q)
      ST_IDLE: req_ready = 1'b1;
      ST_ADDR: begin
        mem_valid = 1'b1;
        mem_addr  = {addr_q[p_ADDR_BITS-1:2], 2'b00};
        mem_cmd   = cmd_q;
      end
      ST_RDATA: mem_r_ready = 1'b1;
      ST_WDATA: begin
        mem_w_valid = 1'b1;
        mem_w_strb  = fmt_strb;
        mem_w_data  = fmt_wdata_rep;
      end
      ST_RESP: begin
        rsp_valid      = 1'b1;
        rsp_rdata      = rdata_q;
        rsp_err        = err_q;
        rsp_misaligned = mis_q;
      end
      default: ;
    endcase
  end

endmodule
